impix_block_avg_slave: RTL and testbench

IMPIX_BLOCK_AVG_SLAVE -- requirements
Module: impix_block_avg_slave

---
 rtl/impix_block_avg_slave.sv | 94 +++++++++
 tb/tb_impix_block_avg_slave.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/impix_block_avg_slave.sv
// impix_block_avg_slave: Avalon-MM responder that averages 2^B x 2^B pixel blocks
// and queues 8-bit rounded averages in a small result FIFO.
module impix_block_avg_slave #(
  parameter int BLOCK_LOG2 = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  output logic        irq
);
  localparam int SH = 2 * BLOCK_LOG2;
  localparam int AW = 8 + SH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [SH-1:0] LAST = '1;
  localparam logic [AW-1:0] HALF = AW'(1) << (SH - 1);
  localparam logic [PW:0] DEPTH = (PW + 1)'(FIFO_DEPTH);

  logic          enable, irq_en;
  logic [AW-1:0] acc, sum, rnd;
  logic [SH-1:0] cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0]   level;
  logic          full, empty, wr, rd, pix, push, pop, clr;
  logic [31:0]   status, rdata;
  logic          unused_bits;

  assign full   = level == DEPTH;
  assign empty  = level == '0;
  assign sum    = acc + AW'(avs_writedata[7:0]);
  assign rnd    = sum + HALF;
  // The last pixel of a block cannot be absorbed while the FIFO has no room for its average
  assign avs_waitrequest = avs_write && avs_address == 2'd2 && enable && cnt == LAST && full;
  assign wr     = avs_write && !avs_waitrequest;
  assign rd     = avs_read && !avs_write;
  assign pix    = wr && avs_address == 2'd2 && enable;
  assign push   = pix && cnt == LAST;
  assign pop    = rd && avs_address == 2'd3 && !empty;
  assign clr    = wr && avs_address == 2'd0 && avs_writedata[0];
  assign status = {8'b0, 8'(cnt), 6'b0, full, empty, 3'b0, 5'(level)};
  assign unused_bits = ^{avs_writedata[31:8], rnd[SH-1:0]};

  always_comb
    rdata = avs_address == 2'd0 ? {29'b0, irq_en, enable, 1'b0} :
            avs_address == 2'd1 ? status :
            (avs_address == 2'd3 && !empty) ? {1'b1, 23'b0, mem[rp]} : '0;

  always_ff @(posedge clk_clk)
    if (push) mem[wp] <= rnd[AW-1:SH];

  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      enable            <= 1'b0;
      irq_en            <= 1'b0;
      acc               <= '0;
      cnt               <= '0;
      wp                <= '0;
      rp                <= '0;
      level             <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      irq               <= 1'b0;
    end else begin
      if (wr && avs_address == 2'd0) begin
        enable <= avs_writedata[1];
        irq_en <= avs_writedata[2];
      end
      if (clr) begin
        acc   <= '0;
        cnt   <= '0;
        wp    <= '0;
        rp    <= '0;
        level <= '0;
      end else begin
        if (pix) begin
          acc <= push ? '0 : sum;
          cnt <= cnt + 1'b1;
        end
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        if (push != pop) level <= push ? level + 1'b1 : level - 1'b1;
      end
      avs_readdatavalid <= rd;
      if (rd) avs_readdata <= rdata;
      irq <= irq_en && !empty;
    end
endmodule

// File: tb/tb_impix_block_avg_slave.sv
// tb_impix_block_avg_slave: randomized self-checking bench against a queue-based
// model of block averaging, result FIFO and register map.
module tb_impix_block_avg_slave;
  logic        clk, rst_n;
  logic [1:0]  address;
  logic        read, write;
  logic [31:0] writedata, readdata;
  logic        readdatavalid, waitrequest, irq;
  int          passed = 0, total = 0;
  int          q[$], blk[$];
  bit          m_en;

  impix_block_avg_slave dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(address), .avs_read(read),
    .avs_write(write), .avs_writedata(writedata), .avs_readdata(readdata),
    .avs_readdatavalid(readdatavalid), .avs_waitrequest(waitrequest), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_clear();
    q.delete();
    blk.delete();
  endfunction

  function automatic void m_pixel(int p);
    int s = 0;
    if (!m_en) return;
    blk.push_back(p & 255);
    if (blk.size() == 16) begin
      foreach (blk[i]) s += blk[i];
      q.push_back((s + 8) / 16);
      blk.delete();
    end
  endfunction

  function automatic logic [31:0] m_status();
    return (blk.size() << 16) | ((q.size() == 8) << 9) | ((q.size() == 0) << 8) | q.size();
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    int n = 0;
    address = a; writedata = d; write = 1'b1; read = 1'b0;
    #1;
    while (waitrequest && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (waitrequest) begin
      total++;
      $display("FAIL write_timeout addr=%0d waitrequest still=%b required=0", a, waitrequest);
    end
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic v);
    address = a; read = 1'b1; write = 1'b0;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
    v = readdatavalid;
  endtask

  task automatic ctrl(input logic [31:0] d);
    bus_write(2'd0, d);
    if (d[0]) m_clear();
    m_en = d[1];
  endtask

  task automatic px(input int p);
    bus_write(2'd2, ($urandom & 32'hFFFFFF00) | (p & 255));
    m_pixel(p);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    total++; if ({readdata, readdatavalid, irq, waitrequest} !== 35'd0)
      $display("FAIL reset_outputs got=%h/%b/%b/%b required=0", readdata, readdatavalid, irq, waitrequest); else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    bus_read(2'd1, d, v);
    total++; if (d !== 32'h100 || v !== 1'b1) $display("FAIL reset_status got=%h v=%b required=00000100 v=1", d, v); else passed++;
    bus_read(2'd0, d, v);
    total++; if (d !== 32'h0) $display("FAIL reset_ctrl got=%h required=0", d); else passed++;
  endtask

  task automatic test_basic();
    logic [31:0] d; logic v;
    ctrl(32'h2);
    for (int i = 0; i < 16; i++) px(8'h10);
    bus_read(2'd1, d, v);
    total++; if (d !== 32'h1) $display("FAIL basic_status got=%h required=00000001", d); else passed++;
    bus_read(2'd3, d, v);
    total++; if (d !== 32'h80000010 || v !== 1'b1) $display("FAIL basic_result got=%h v=%b required=80000010 v=1", d, v); else passed++;
    void'(q.pop_front());
    bus_read(2'd1, d, v);
    total++; if (d !== 32'h100) $display("FAIL basic_empty got=%h required=00000100", d); else passed++;
  endtask

  task automatic test_rounding();
    logic [31:0] d; logic v;
    logic [31:0] exp [3] = '{32'h80000008, 32'h80000001, 32'h800000FF};
    for (int i = 0; i < 16; i++) px(i);
    for (int i = 0; i < 15; i++) px(0);
    px(8);
    for (int i = 0; i < 16; i++) px(255);
    for (int i = 0; i < 3; i++) begin
      bus_read(2'd3, d, v);
      total++; if (d !== exp[i]) $display("FAIL rounding_%0d got=%h required=%h", i, d, exp[i]); else passed++;
      void'(q.pop_front());
    end
  endtask

  task automatic test_random();
    logic [31:0] d; logic v;
    int k;
    ctrl(32'h3);
    k = 64 + $urandom_range(1, 15);
    for (int i = 0; i < k; i++) px($urandom_range(0, 255));
    bus_read(2'd1, d, v);
    total++; if (d !== m_status()) $display("FAIL random_status got=%h required=%h", d, m_status()); else passed++;
    while (q.size() > 0) begin
      bus_read(2'd3, d, v);
      total++; if (d !== (32'h80000000 | q[0])) $display("FAIL random_result got=%h required=%h", d, 32'h80000000 | q[0]); else passed++;
      void'(q.pop_front());
    end
    bus_read(2'd1, d, v);
    total++; if (d !== m_status()) $display("FAIL random_drained got=%h required=%h", d, m_status()); else passed++;
  endtask

  task automatic test_side_effects();
    logic [31:0] d; logic v;
    ctrl(32'h1);
    bus_read(2'd3, d, v);
    total++; if (d !== 32'h0 || v !== 1'b1) $display("FAIL empty_result got=%h v=%b required=0 v=1", d, v); else passed++;
    for (int i = 0; i < 5; i++) px($urandom_range(0, 255));
    bus_read(2'd1, d, v);
    total++; if (d !== 32'h100) $display("FAIL disabled_pixels got=%h required=00000100", d); else passed++;
    ctrl(32'h2);
    for (int i = 0; i < 3; i++) px($urandom_range(0, 255));
    bus_write(2'd1, $urandom);
    bus_write(2'd3, $urandom);
    bus_read(2'd2, d, v);
    total++; if (d !== 32'h0 || v !== 1'b1) $display("FAIL pixel_read got=%h v=%b required=0 v=1", d, v); else passed++;
    address = 2'd1; writedata = $urandom; read = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    total++; if (readdatavalid !== 1'b0) $display("FAIL rw_collision valid=%b required=0", readdatavalid); else passed++;
    bus_read(2'd1, d, v);
    total++; if (d !== m_status() || d !== 32'h00030100) $display("FAIL side_effect_status got=%h required=00030100", d); else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] d; logic v;
    int p;
    ctrl(32'h3);
    for (int i = 0; i < 8 * 16 + 15; i++) px($urandom_range(0, 255));
    bus_read(2'd1, d, v);
    total++; if (d !== 32'h000F0208) $display("FAIL full_status got=%h required=000F0208", d); else passed++;
    p = $urandom_range(0, 255);
    address = 2'd2; writedata = p; write = 1'b1;
    #1;
    total++; if (waitrequest !== 1'b1) $display("FAIL stall_assert waitrequest=%b required=1", waitrequest); else passed++;
    repeat (3) @(posedge clk);
    #2;
    total++; if (waitrequest !== 1'b1) $display("FAIL stall_hold waitrequest=%b required=1", waitrequest); else passed++;
    write = 1'b0;
    @(posedge clk); #1;
    bus_read(2'd1, d, v);
    total++; if (d !== 32'h000F0208) $display("FAIL stall_no_change got=%h required=000F0208", d); else passed++;
    bus_read(2'd3, d, v);
    total++; if (d !== (32'h80000000 | q[0])) $display("FAIL stall_pop got=%h required=%h", d, 32'h80000000 | q[0]); else passed++;
    void'(q.pop_front());
    address = 2'd2; writedata = p; write = 1'b1;
    #1;
    total++; if (waitrequest !== 1'b0) $display("FAIL stall_release waitrequest=%b required=0", waitrequest); else passed++;
    @(posedge clk); #1;
    write = 1'b0;
    m_pixel(p);
    bus_read(2'd1, d, v);
    total++; if (d !== 32'h208) $display("FAIL stall_level got=%h required=00000208", d); else passed++;
    while (q.size() > 0) begin
      bus_read(2'd3, d, v);
      total++; if (d !== (32'h80000000 | q[0])) $display("FAIL stall_order got=%h required=%h", d, 32'h80000000 | q[0]); else passed++;
      void'(q.pop_front());
    end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic v;
    ctrl(32'h7);
    for (int i = 0; i < 16; i++) px($urandom_range(0, 255));
    total++; if (irq !== 1'b0) $display("FAIL irq_lag irq=%b required=0", irq); else passed++;
    @(posedge clk); #1;
    total++; if (irq !== 1'b1) $display("FAIL irq_rise irq=%b required=1", irq); else passed++;
    bus_read(2'd3, d, v);
    void'(q.pop_front());
    @(posedge clk); #1;
    total++; if (irq !== 1'b0) $display("FAIL irq_fall irq=%b required=0", irq); else passed++;
    for (int i = 0; i < 5 * 16 + 7; i++) px($urandom_range(0, 255));
    bus_read(2'd1, d, v);
    total++; if (d !== 32'h00070005) $display("FAIL pre_clear got=%h required=00070005", d); else passed++;
    ctrl(32'h7);
    bus_read(2'd1, d, v);
    total++; if (d !== 32'h100) $display("FAIL post_clear got=%h required=00000100", d); else passed++;
    bus_read(2'd0, d, v);
    total++; if (d !== 32'h6) $display("FAIL ctrl_read got=%h required=00000006", d); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic v;
    ctrl(32'h7);
    for (int i = 0; i < 3 * 16 + 5; i++) px($urandom_range(0, 255));
    bus_read(2'd1, d, v);
    total++; if (d !== 32'h00050003 || irq !== 1'b1) $display("FAIL pre_reset got=%h irq=%b required=00050003 irq=1", d, irq); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({readdata, readdatavalid, irq, waitrequest} !== 35'd0)
      $display("FAIL async_reset got=%h/%b/%b/%b required=0", readdata, readdatavalid, irq, waitrequest); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_clear();
    m_en = 1'b0;
    bus_read(2'd1, d, v);
    total++; if (d !== 32'h100) $display("FAIL post_reset_status got=%h required=00000100", d); else passed++;
    ctrl(32'h2);
    for (int i = 0; i < 16; i++) px(8'h20);
    bus_read(2'd3, d, v);
    total++; if (d !== 32'h80000020) $display("FAIL post_reset_block got=%h required=80000020", d); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0; m_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_rounding();
    test_random();
    test_side_effects();
    test_stall();
    test_irq();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
